// File: rtl/bp_be_pkg.sv
// Shared types for the loop-inference scheduler: FSM states and the
// response struct macro. Watchdog build option: BP_BE_LOOP_INF_SCHED_TIMEOUT_EN.
`ifndef BP_BE_PKG_SV
`define BP_BE_PKG_SV

`define BP_BE_DECLARE_LOOP_SCHED_RESP_S(id_width_mp, count_width_mp) \
  typedef struct packed {                                             \
    logic [id_width_mp-1:0]    id;                                     \
    logic [count_width_mp-1:0] count;                                  \
    logic                      timeout;                                \
  } bp_be_loop_sched_resp_s

package bp_be_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DISCOVER,
    CONFIRMED,
    RESP
  } bp_be_loop_sched_state_e;

endpackage

`endif

// File: rtl/bp_be_loop_inference_sched_if.sv
// Response channel of the loop-inference scheduler (valid/ready).
// Master drives the estimate, slave returns ready.
interface bp_be_loop_inference_sched_if #(
  parameter int num_req_p      = 4,
  parameter int output_range_p = 8
);

  localparam int id_w_lp = $clog2(num_req_p);

  logic                      resp_v_o;
  logic [id_w_lp-1:0]        resp_id_o;
  logic [output_range_p-1:0] resp_count_o;
  logic                      resp_timeout_o;
  logic                      resp_ready_and_i;

  modport master (
    output resp_v_o,
    output resp_id_o,
    output resp_count_o,
    output resp_timeout_o,
    input  resp_ready_and_i
  );

  modport slave (
    input  resp_v_o,
    input  resp_id_o,
    input  resp_count_o,
    input  resp_timeout_o,
    output resp_ready_and_i
  );

endinterface

// File: rtl/bsg_arb_round_robin.sv
// Combinational round-robin picker: first request at or after ptr_i.
// Grants are gated by en_i; v_o reports any request regardless.
module bsg_arb_round_robin #(
  parameter int num_req_p = 4,
  localparam int id_w_lp  = $clog2(num_req_p)
) (
  input  logic                 en_i,
  input  logic [num_req_p-1:0] reqs_i,
  input  logic [id_w_lp-1:0]   ptr_i,
  output logic [num_req_p-1:0] grants_o,
  output logic [id_w_lp-1:0]   tag_o,
  output logic                 v_o
);

  localparam int sum_w_lp = id_w_lp + 1;
  localparam logic [sum_w_lp-1:0] n_lp = sum_w_lp'(num_req_p);

  logic [sum_w_lp-1:0] idx;

  always_comb begin
    grants_o = '0;
    tag_o    = '0;
    v_o      = 1'b0;
    idx      = '0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = {1'b0, ptr_i} + sum_w_lp'(i);
      if (idx >= n_lp)
        idx = idx - n_lp;
      if (!v_o && reqs_i[idx[id_w_lp-1:0]]) begin
        v_o   = 1'b1;
        tag_o = idx[id_w_lp-1:0];
      end
    end
    if (en_i && v_o)
      grants_o[tag_o] = 1'b1;
  end

endmodule

// File: rtl/bp_be_loop_inference_sched.sv
// Shares one loop-inference engine among striding-load detectors.
// Define BP_BE_LOOP_INF_SCHED_TIMEOUT_EN to build the discovery watchdog.
module bp_be_loop_inference_sched
  import bp_be_pkg::*;
#(
  parameter int num_req_p        = 4,
  parameter int vaddr_width_p    = 39,
  parameter int output_range_p   = 8,
  parameter int timeout_cycles_p = 256,
  localparam int id_w_lp         = $clog2(num_req_p)
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [num_req_p-1:0]               req_v_i,
  input  logic [num_req_p*vaddr_width_p-1:0] req_pc_i,
  output logic [num_req_p-1:0]               req_yumi_o,
  input  logic [num_req_p-1:0]               confirm_i,
  output logic                               start_discovery_o,
  output logic                               confirm_discovery_o,
  output logic [vaddr_width_p-1:0]           striding_pc_o,
  input  logic                               engine_v_i,
  input  logic [output_range_p-1:0]          engine_count_i,
  output logic                               engine_yumi_o,
  bp_be_loop_inference_sched_if.master       resp_if
);

  `BP_BE_DECLARE_LOOP_SCHED_RESP_S(id_w_lp, output_range_p);

  bp_be_loop_sched_state_e state_r, state_n;
  bp_be_loop_sched_resp_s  resp_r;

  logic [id_w_lp-1:0]       ptr_r;
  logic [vaddr_width_p-1:0] pc_r;
  logic [num_req_p-1:0]     arb_grants;
  logic [id_w_lp-1:0]       arb_tag;
  logic                     arb_v;
  logic                     confirm_hit;
  logic                     timeout_hit;

  bsg_arb_round_robin #(
    .num_req_p(num_req_p)
  ) arb (
    .en_i    (state_r == IDLE),
    .reqs_i  (req_v_i),
    .ptr_i   (ptr_r),
    .grants_o(arb_grants),
    .tag_o   (arb_tag),
    .v_o     (arb_v)
  );

  // Only the latched winner's confirm line matters.
  assign confirm_hit = confirm_i[resp_r.id];

`ifdef BP_BE_LOOP_INF_SCHED_TIMEOUT_EN
  localparam int wd_w_lp = $clog2(timeout_cycles_p + 1);
  localparam logic [wd_w_lp-1:0] wd_last_lp =
    wd_w_lp'(timeout_cycles_p - 1);
  localparam logic [wd_w_lp-1:0] wd_max_lp =
    wd_w_lp'(timeout_cycles_p);

  logic [wd_w_lp-1:0] wd_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      wd_r <= '0;
    else if (state_r == START)
      wd_r <= '0;
    else if (state_r == DISCOVER && !confirm_hit
             && wd_r != wd_max_lp)
      wd_r <= wd_r + 1'b1;
  end

  assign timeout_hit = (state_r == DISCOVER)
                    && (wd_r == wd_last_lp);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      state_r <= IDLE;
    else
      state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      IDLE:      if (arb_v) state_n = START;
      START:     state_n = DISCOVER;
      DISCOVER: begin
        if (confirm_hit)      state_n = CONFIRMED;
        else if (timeout_hit) state_n = RESP;
      end
      CONFIRMED: if (engine_v_i) state_n = RESP;
      RESP:      if (resp_if.resp_ready_and_i) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_comb begin
    req_yumi_o          = arb_grants;
    start_discovery_o   = (state_r == START);
    confirm_discovery_o = (state_r == DISCOVER) && confirm_hit;
    engine_yumi_o       = (state_r == CONFIRMED) && engine_v_i;
    striding_pc_o       = pc_r;
  end

  assign resp_if.resp_v_o       = (state_r == RESP);
  assign resp_if.resp_id_o      = resp_r.id;
  assign resp_if.resp_count_o   = resp_r.count;
  assign resp_if.resp_timeout_o = resp_r.timeout;

  // Confirm beats expiry, so the timeout response loads only without it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_r  <= '0;
      pc_r   <= '0;
      resp_r <= '0;
    end else begin
      case (state_r)
        IDLE: if (arb_v) begin
          resp_r.id <= arb_tag;
          pc_r <= req_pc_i[arb_tag*vaddr_width_p +: vaddr_width_p];
        end
        DISCOVER: if (!confirm_hit && timeout_hit) begin
          resp_r.count   <= '0;
          resp_r.timeout <= 1'b1;
        end
        CONFIRMED: if (engine_v_i) begin
          resp_r.count   <= engine_count_i;
          resp_r.timeout <= 1'b0;
        end
        RESP: if (resp_if.resp_ready_and_i) begin
          if (resp_r.id == id_w_lp'(num_req_p - 1))
            ptr_r <= '0;
          else
            ptr_r <= resp_r.id + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
